// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count_checker block.
package count_checker_pkg;

    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating statistics counter; clear takes priority over increment.
module sat_counter
    import count_checker_pkg::*;
#(
    parameter int W = STAT_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/count_checker.sv
// Lock-and-track checker for an external free-running counter.
// Optional wrap/reset statistics are enabled by defining COUNT_CHECKER_WRAP_STATS_EN.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_vld,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic              rst_pulse,
    output logic [STAT_W-1:0] err_cnt,
    output logic [STAT_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]  expected
);

    localparam int MW = $clog2(SYNC_LEN + 1);

    state_t           r_state;
    logic [MW-1:0]    r_match;
    logic [WIDTH-1:0] r_expected;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_rst_pulse;

    logic             w_match;
    logic             w_in_lock;
    logic             w_rst_det;
    logic             w_err;
    logic [WIDTH-1:0] w_next_exp;
    logic [MW-1:0]    w_match_inc;

    assign w_match     = (count_in == r_expected);
    assign w_in_lock   = (r_state == ST_LOCKED);
    assign w_next_exp  = count_in + WIDTH'(1);
    assign w_match_inc = r_match + MW'(1);

`ifdef COUNT_CHECKER_WRAP_STATS_EN
    logic w_zero;
    logic w_wrap_inc;

    assign w_zero     = (count_in == '0);
    // A jump to zero while locked is a counter reset, not a sequence error.
    assign w_rst_det  = count_vld && w_in_lock && !w_match && w_zero;
    assign w_wrap_inc = count_vld && w_in_lock && w_match && w_zero;

    sat_counter #(.W(STAT_W)) u_wrap_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_wrap_inc),
        .clr     (clr_stats),
        .cnt     (wrap_cnt)
    );
`else
    assign w_rst_det = 1'b0;
    assign wrap_cnt  = '0;
`endif

    assign w_err = count_vld && w_in_lock && !w_match && !w_rst_det;

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_err),
        .clr     (clr_stats),
        .cnt     (err_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_UNLOCKED;
            r_match     <= '0;
            r_expected  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_rst_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
            r_rst_pulse <= w_rst_det;
            if (count_vld) begin
                r_expected <= w_next_exp;
                case (r_state)
                    ST_UNLOCKED: begin
                        r_match <= '0;
                        r_state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (w_match) begin
                            r_match <= w_match_inc;
                            if (w_match_inc >= MW'(SYNC_LEN)) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_err) begin
                            r_match  <= '0;
                            r_state  <= ST_SYNC;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_UNLOCKED;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign rst_pulse = r_rst_pulse;
    assign expected  = r_expected;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed scenarios then random traffic against a reference model.
module tb_count_checker;

    localparam int WIDTH    = 4;
    localparam int SYNC_LEN = 2;
    localparam int MOD      = 1 << WIDTH;
`ifdef COUNT_CHECKER_WRAP_STATS_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] count_in;
    logic             count_vld;
    logic             clr_stats;
    logic             locked;
    logic             err_pulse;
    logic             rst_pulse;
    logic [7:0]       err_cnt;
    logic [7:0]       wrap_cnt;
    logic [WIDTH-1:0] expected;

    int total = 0;
    int bad   = 0;

    // Reference model: "seen anything", "locked", current run of good increments.
    bit m_seen, m_locked, m_err, m_rst;
    int m_run, m_errc, m_wrapc, m_exp;

    count_checker #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .count_in  (count_in),
        .count_vld (count_vld),
        .clr_stats (clr_stats),
        .locked    (locked),
        .err_pulse (err_pulse),
        .rst_pulse (rst_pulse),
        .err_cnt   (err_cnt),
        .wrap_cnt  (wrap_cnt),
        .expected  (expected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_locked = 0; m_err = 0; m_rst = 0;
        m_run = 0; m_errc = 0; m_wrapc = 0; m_exp = 0;
    endtask

    task automatic model_step(input bit vld, input int val, input bit clr);
        m_err = 0;
        m_rst = 0;
        if (vld) begin
            if (!m_seen) begin
                m_seen = 1;
                m_run  = 0;
            end else if (m_locked) begin
                if (val == m_exp) begin
                    if (val == 0 && WRAP_EN) m_wrapc = (m_wrapc < 255) ? m_wrapc + 1 : 255;
                end else if (val == 0 && WRAP_EN) begin
                    m_rst = 1;
                end else begin
                    m_err    = 1;
                    m_errc   = (m_errc < 255) ? m_errc + 1 : 255;
                    m_locked = 0;
                    m_run    = 0;
                end
            end else if (val == m_exp) begin
                m_run++;
                if (m_run >= SYNC_LEN) m_locked = 1;
            end else begin
                m_run = 0;
            end
            m_exp = (val + 1) % MOD;
        end
        if (clr) begin
            m_errc  = 0;
            m_wrapc = 0;
        end
    endtask

    task automatic check_all(input string when);
        check({when, ".locked"},    32'(locked),    32'(m_locked));
        check({when, ".err_pulse"}, 32'(err_pulse), 32'(m_err));
        check({when, ".rst_pulse"}, 32'(rst_pulse), 32'(m_rst));
        check({when, ".err_cnt"},   32'(err_cnt),   32'(m_errc));
        check({when, ".wrap_cnt"},  32'(wrap_cnt),  32'(m_wrapc));
        check({when, ".expected"},  32'(expected),  32'(m_exp));
    endtask

    task automatic step(input bit vld, input int val, input bit clr, input string when);
        logic [31:0] v;
        v = 32'(val);
        @(negedge clk);
        count_vld = vld;
        count_in  = v[WIDTH-1:0];
        clr_stats = clr;
        model_step(vld, val, clr);
        @(posedge clk);
        #1;
        check_all(when);
    endtask

    initial begin
        int e;
        reset_n   = 1'b0;
        count_vld = 1'b0;
        count_in  = '0;
        clr_stats = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Lock on 3,4,5,6
        step(1, 3, 0, "lock3");
        step(1, 4, 0, "lock4");
        step(1, 5, 0, "lock5");
        check("locked_after_5", 32'(locked), 32'd1);
        step(1, 6, 0, "lock6");
        check("expected_after_6", 32'(expected), 32'd7);

        // Run up through the wrap
        for (int v = 7; v <= 15; v++) step(1, v, 0, "run");
        step(1, 0, 0, "wrap0");
        step(1, 1, 0, "wrap1");
        check("wrap_cnt_after_wrap", 32'(wrap_cnt), 32'(WRAP_EN));
        check("locked_after_wrap", 32'(locked), 32'd1);
        check("err_cnt_after_wrap", 32'(err_cnt), 32'd0);

        // Jump to zero while locked at 7
        for (int v = 2; v <= 7; v++) step(1, v, 0, "to7");
        step(1, 0, 0, "jump0");
        check("rst_pulse_on_jump", 32'(rst_pulse), 32'(WRAP_EN));
        check("err_pulse_on_jump", 32'(err_pulse), 32'(!WRAP_EN));
        check("expected_after_jump", 32'(expected), 32'd1);
        step(0, 0, 0, "jump_gap");
        check("rst_pulse_one_cycle", 32'(rst_pulse), 32'd0);

        // Relock, then a real error at 9
        for (int v = 1; v <= 7; v++) step(1, v, 0, "relock7");
        step(1, 9, 0, "err9");
        check("err_pulse_on_9", 32'(err_pulse), 32'd1);
        check("locked_drop_on_9", 32'(locked), 32'd0);
        check("err_cnt_on_9", 32'(err_cnt), WRAP_EN ? 32'd1 : 32'd2);
        step(1, 10, 0, "sync10");
        check("err_pulse_one_cycle", 32'(err_pulse), 32'd0);
        step(1, 11, 0, "sync11");
        check("relocked_on_11", 32'(locked), 32'd1);

        // Saturate err_cnt with 300 forced errors
        for (int i = 0; i < 300; i++) begin
            e = (m_exp + 3) % MOD;
            if (e == 0) e = (m_exp + 4) % MOD;
            step(1, e, 0, "sat_err");
            step(1, m_exp, 0, "sat_m1");
            step(1, m_exp, 0, "sat_m2");
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);
        e = (m_exp + 3) % MOD;
        if (e == 0) e = (m_exp + 4) % MOD;
        step(1, e, 1, "clr_vs_err");
        check("err_cnt_clear_wins", 32'(err_cnt), 32'd0);

        // Asynchronous reset mid-SYNC with valid gaps
        step(1, m_exp, 0, "midsync1");
        step(0, 3, 0, "midsync_gap1");
        step(0, 12, 0, "midsync_gap2");
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step(1, 8, 0, "rl8");
        step(0, 0, 0, "rl_gap1");
        step(1, 9, 0, "rl9");
        check("not_locked_after_2", 32'(locked), 32'd0);
        step(0, 5, 0, "rl_gap2");
        step(1, 10, 0, "rl10");
        check("locked_after_3", 32'(locked), 32'd1);

        // Random traffic biased toward in-sequence values
        for (int i = 0; i < 600; i++) begin
            int r, val;
            bit vld, clr;
            r   = int'($urandom_range(0, 99));
            vld = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            if (r < 70)      val = m_exp;
            else if (r < 82) val = 0;
            else             val = int'($urandom_range(0, MOD - 1));
            step(vld, val, clr, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the observed count.
REQ-002 Parameter SYNC_LEN, default 2: consecutive correct increments required to lock.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 count_in  input  WIDTH  observed counter value.
REQ-006 count_vld  input  1  count_in is sampled only on cycles where this is high.
REQ-007 clr_stats  input  1  synchronous clear of the statistics counters.
REQ-008 locked  output  1  high while the checker tracks the sequence.
REQ-009 err_pulse  output  1  one-cycle pulse on a sequence error while locked.
REQ-010 rst_pulse  output  1  one-cycle pulse on a detected counter reset (jump to 0) while locked.
REQ-011 err_cnt  output  8  saturating count of sequence errors.
REQ-012 wrap_cnt  output  8  saturating count of max-to-0 wraps.
REQ-013 expected  output  WIDTH  next value the checker expects.

Function
REQ-014 The FSM SHALL have three states: UNLOCKED, SYNC and LOCKED.
REQ-015 UNLOCKED, count_vld=1: expected <= count_in+1 mod 2^WIDTH; match count <= 0; go to SYNC.
REQ-016 SYNC, count_vld=1, count_in==expected: increment the match count; go to LOCKED once the match count reaches SYNC_LEN.
REQ-017 SYNC, count_vld=1, mismatch: match count <= 0; stay in SYNC; no err_pulse.
REQ-018 SYNC and LOCKED, every count_vld=1: expected <= count_in+1 mod 2^WIDTH.
REQ-019 LOCKED, count_in==expected: stay in LOCKED; if count_in==0 (wrap from 2^WIDTH-1), increment wrap_cnt.
REQ-020 LOCKED, mismatch with count_in==0: counter reset. rst_pulse=1, no error, stay in LOCKED.
REQ-021 LOCKED, any other mismatch: err_pulse=1; increment err_cnt; match count <= 0; go to SYNC; locked drops.
REQ-022 count_vld=0: no state, expected or counter change.
REQ-023 All outputs SHALL be registered, updated the cycle after the sample edge (latency 1).
REQ-024 Arithmetic on expected SHALL wrap modulo 2^WIDTH.
REQ-025 err_cnt and wrap_cnt SHALL saturate at 255 (no wrap).
REQ-026 clr_stats SHALL zero err_cnt and wrap_cnt.
- clr_stats coincident with an increment: the clear wins.
- clr_stats does not affect the FSM.
REQ-027 locked SHALL equal (state==LOCKED).

Reset
REQ-028 reset_n low SHALL asynchronously force the following, from any state including mid-SYNC:
- state UNLOCKED, match count 0
- locked, err_pulse, rst_pulse = 0
- err_cnt, wrap_cnt, expected = 0
REQ-029 The first count_vld after reset release SHALL be handled per REQ-015.

Configuration
REQ-030 Macro COUNT_CHECKER_WRAP_STATS_EN:
- Defined: wrap_cnt and rst_pulse behave as specified.
- Undefined: wrap_cnt is tied to 0 and rst_pulse to 0; a jump to 0 while locked is treated as an error per REQ-021.

Structure
REQ-031 Package count_checker_pkg SHALL hold the FSM state enum and the constant STAT_W=8.
REQ-032 Submodule sat_counter (STAT_W wide; inc, clr inputs; clear priority) SHALL implement err_cnt and wrap_cnt.

Verification
REQ-033 The bench SHALL cover these directed scenarios (WIDTH=4, SYNC_LEN=2, macro defined):
- Feed 3,4,5,6 with count_vld=1 every cycle -> locked=1 the cycle after sampling 5; expected=7.
- Locked; feed 14,15,0,1 -> wrap_cnt=1; no err_pulse; locked stays 1.
- Locked at 7; feed 0 -> rst_pulse for one cycle; err_cnt unchanged; expected=1.
- Locked at 7; feed 9 -> err_pulse for one cycle; err_cnt=1; locked=0; then 10,11 -> locked=1.
- Force 300 errors -> err_cnt=255; clr_stats coincident with an error -> err_cnt=0.
- reset_n low mid-SYNC with count_vld gaps -> all outputs 0 immediately; relock needs 3 valid samples.
- Rerun the reset-detection scenario with the macro undefined -> err_pulse asserted, wrap_cnt=0.
